// File: rtl/fifo_p1o3_reader_pkg.sv
// Shared definitions for the pop-1/out-3 FIFO reader: state encoding and window packing.
// Also used by fifo_p1o3 and the PE array so all three agree on window layout.
package fifo_p1o3_reader_pkg;

   localparam int NUM_RDATA   = 3;
   localparam int NUM_DISCARD = 2;
   localparam int MIN_ROW_LEN = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WIN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } rd_state_e;

   // Width of one packed window {w2,w1,w0}.
   function automatic int win_bits(input int dat_width);
      return dat_width * NUM_RDATA;
   endfunction

endpackage

// File: rtl/fifo_p1o3_reader_skid.sv
// Two-entry valid/ready buffer with registered outputs, plus its overflow checker.
// Entry 0 (head) drives the output; entry 1 (skid) holds a word that arrives during a stall.
module win_skid_buf2 #(
   parameter int WIDTH = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_push,
   output logic [WIDTH-1:0] out_data,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [1:0]       occ
);

   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] skid_r;
   logic [1:0]       occ_r;
   logic             pop_s;

   assign pop_s    = out_vld && out_rdy;
   assign out_data = head_r;
   assign out_vld  = (occ_r != 2'd0);
   assign occ      = occ_r;

   // Occupancy-driven push/pop; head always holds the oldest entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r <= {WIDTH{1'b0}};
         skid_r <= {WIDTH{1'b0}};
         occ_r  <= 2'd0;
      end else begin
         case (occ_r)
            2'd0: begin
               if (in_push) begin
                  head_r <= in_data;
                  occ_r  <= 2'd1;
               end
            end
            2'd1: begin
               if (in_push && pop_s) begin
                  head_r <= in_data;
               end else if (in_push) begin
                  skid_r <= in_data;
                  occ_r  <= 2'd2;
               end else if (pop_s) begin
                  occ_r  <= 2'd0;
               end
            end
            2'd2: begin
               if (pop_s) begin
                  head_r <= skid_r;
                  if (in_push) begin
                     skid_r <= in_data;
                  end else begin
                     occ_r  <= 2'd1;
                  end
               end
            end
            default: occ_r <= 2'd0;
         endcase
      end
   end

   win_skid_buf2_chk u_chk (
      .clk     (clk),
      .rst     (rst),
      .in_push (in_push),
      .occ     (occ_r)
   );

endmodule

module win_skid_buf2_chk (
   input logic       clk,
   input logic       rst,
   input logic       in_push,
   input logic [1:0] occ
);

   // The upstream credit rule must never let a capture land on a full buffer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(in_push && (occ == 2'd2)))
            else $error("win_skid_buf2: capture while buffer full");
      end
   end

endmodule

// File: rtl/fifo_p1o3_reader.sv
// Consumer side of the pop-1/out-3 FIFO: issues window and row-tail discard pops,
// tags each pop in flight, and presents windows through a 2-entry valid/ready buffer.
module fifo_p1o3_reader
   import fifo_p1o3_reader_pkg::*;
#(
   parameter int DAT_WIDTH     = 8,
   parameter int FF_ADDR_WIDTH = 3,
   parameter int LEN_WIDTH     = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [LEN_WIDTH-1:0]           row_len,
   input  logic [LEN_WIDTH-1:0]           num_rows,
   output logic                           ff_rd_req,
   input  logic [DAT_WIDTH*NUM_RDATA-1:0] ff_rd_data,
   input  logic                           ff_rd_data_vld,
   input  logic [FF_ADDR_WIDTH:0]         ff_data_counter,
   output logic [DAT_WIDTH*NUM_RDATA-1:0] win_data,
   output logic                           win_vld,
   input  logic                           win_rdy,
   output logic                           win_last,
   output logic                           busy,
   output logic                           done,
   output logic                           cfg_err
);

   localparam int WIN_W = win_bits(DAT_WIDTH);
   localparam int CNT_W = FF_ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]     CNT_WIN    = CNT_W'(NUM_RDATA);
   localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [LEN_WIDTH-1:0] LEN_MIN    = LEN_WIDTH'(MIN_ROW_LEN);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] LEN_ZERO   = {LEN_WIDTH{1'b0}};
   localparam logic [LEN_WIDTH-1:0] FLUSH_LAST = LEN_WIDTH'(NUM_DISCARD - 1);

   rd_state_e            state_r;
   logic [LEN_WIDTH-1:0] row_len_r;
   logic [LEN_WIDTH-1:0] num_rows_r;
   logic [LEN_WIDTH-1:0] pop_cnt_r;
   logic [LEN_WIDTH-1:0] row_cnt_r;
   logic                 tag_vld_r;
   logic                 tag_disc_r;
   logic                 tag_last_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 cfg_err_r;

   logic                 rd_req_s;
   logic                 credit_s;
   logic                 win_end_s;
   logic                 flush_end_s;
   logic                 rows_end_s;
   logic                 capture_s;
   logic [1:0]           buf_occ_s;
   logic [WIN_W:0]       buf_out_s;

   assign win_end_s   = (pop_cnt_r == (row_len_r - LEN_MIN));
   assign flush_end_s = (pop_cnt_r == FLUSH_LAST);
   assign rows_end_s  = (row_cnt_r == (num_rows_r - LEN_ONE));
   // A pop still in flight already owns a buffer slot.
   assign credit_s    = (({1'b0, buf_occ_s} + {2'b00, tag_vld_r}) < 3'd2);
   assign capture_s   = ff_rd_data_vld && tag_vld_r && !tag_disc_r;

   // Pop request decode; must drop immediately while reset is held.
   always_comb begin
      rd_req_s = 1'b0;
      if (rst) begin
         rd_req_s = 1'b0;
      end else begin
         case (state_r)
            ST_WIN:   rd_req_s = (ff_data_counter >= CNT_WIN) && credit_s;
            ST_FLUSH: rd_req_s = (ff_data_counter != CNT_ZERO);
            default:  rd_req_s = 1'b0;
         endcase
      end
   end

   // Job FSM, pop/row counters, in-flight tag and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         row_len_r  <= LEN_ZERO;
         num_rows_r <= LEN_ZERO;
         pop_cnt_r  <= LEN_ZERO;
         row_cnt_r  <= LEN_ZERO;
         tag_vld_r  <= 1'b0;
         tag_disc_r <= 1'b0;
         tag_last_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         cfg_err_r  <= 1'b0;
      end else begin
         done_r     <= 1'b0;
         cfg_err_r  <= 1'b0;
         tag_vld_r  <= rd_req_s;
         tag_disc_r <= (state_r == ST_FLUSH);
         tag_last_r <= (state_r == ST_WIN) && win_end_s;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  if ((row_len < LEN_MIN) || (num_rows == LEN_ZERO)) begin
                     cfg_err_r <= 1'b1;
                  end else begin
                     row_len_r  <= row_len;
                     num_rows_r <= num_rows;
                     pop_cnt_r  <= LEN_ZERO;
                     row_cnt_r  <= LEN_ZERO;
                     busy_r     <= 1'b1;
                     state_r    <= ST_WIN;
                  end
               end
            end
            ST_WIN: begin
               if (rd_req_s) begin
                  if (win_end_s) begin
                     pop_cnt_r <= LEN_ZERO;
                     state_r   <= ST_FLUSH;
                  end else begin
                     pop_cnt_r <= pop_cnt_r + LEN_ONE;
                  end
               end
            end
            ST_FLUSH: begin
               if (rd_req_s) begin
                  if (flush_end_s) begin
                     pop_cnt_r <= LEN_ZERO;
                     if (rows_end_s) begin
                        state_r <= ST_DRAIN;
                     end else begin
                        row_cnt_r <= row_cnt_r + LEN_ONE;
                        state_r   <= ST_WIN;
                     end
                  end else begin
                     pop_cnt_r <= pop_cnt_r + LEN_ONE;
                  end
               end
            end
            ST_DRAIN: begin
               if ((buf_occ_s == 2'd0) && !tag_vld_r) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   win_skid_buf2 #(
      .WIDTH (WIN_W + 1)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .in_data  ({tag_last_r, ff_rd_data}),
      .in_push  (capture_s),
      .out_data (buf_out_s),
      .out_vld  (win_vld),
      .out_rdy  (win_rdy),
      .occ      (buf_occ_s)
   );

   assign ff_rd_req = rd_req_s;
   assign win_data  = buf_out_s[WIN_W-1:0];
   assign win_last  = buf_out_s[WIN_W];
   assign busy      = busy_r;
   assign done      = done_r;
   assign cfg_err   = cfg_err_r;

endmodule
